// File: rtl/conv_pkg.sv
// conv_pkg: header field layout, packet type codes and feed FSM states shared by the feed controller
package conv_pkg;
    localparam int TYPE_LSB  = 0;
    localparam int CLR_BIT   = 2;
    localparam int START_BIT = 3;
    localparam int LEN_LSB   = 16;

    typedef enum logic [1:0] {T_PARA, T_WEI, T_FTM, T_RSVD} hdr_type_e;
    typedef enum logic [2:0] {S_HDR, S_PARA, S_WEI, S_FTM, S_DROP} feed_state_e;
endpackage

// File: rtl/feed_hdr_decode.sv
// feed_hdr_decode: combinational split of a header word into type, clr, start_after and len
module feed_hdr_decode
    import conv_pkg::*;
#(
    parameter int B_LEN = 16
) (
    input  logic [START_BIT:0] word_ctl,
    input  logic [B_LEN-1:0]   word_len,
    output hdr_type_e          typ,
    output logic               clr,
    output logic               start_after,
    output logic [B_LEN-1:0]   len
);
    assign typ         = hdr_type_e'(word_ctl[TYPE_LSB +: 2]);
    assign clr         = word_ctl[CLR_BIT];
    assign start_after = word_ctl[START_BIT];
    assign len         = word_len;
endmodule

// File: rtl/conv_feed_ctrl.sv
// conv_feed_ctrl: splits a headered stream into conv buffer writes, layer parameter loads and start pulses
module conv_feed_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int B_PARA     = 64,
    parameter int B_LEN      = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    input  logic                  halt,
    input  logic                  fb_full,
    input  logic                  wb_full,
    output logic [DATA_WIDTH-1:0] di,
    output logic                  fb_we,
    output logic                  wb_we,
    output logic                  fb_clr,
    output logic                  wb_clr,
    output logic [B_PARA-1:0]     para,
    output logic                  para_we,
    output logic                  start,
    output logic [1:0]            err
);
    feed_state_e           state_q, state_d;
    logic [B_LEN-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic [B_PARA-1:0]     para_q, para_d;
    logic [1:0]            err_q, err_d;
    logic                  fb_we_q, fb_we_d, wb_we_q, wb_we_d;
    logic                  fb_clr_q, fb_clr_d, wb_clr_q, wb_clr_d;
    logic                  para_we_q, para_we_d, start_q, start_d;
    logic                  start_pend_q, start_pend_d;
    hdr_type_e             h_typ;
    logic                  h_clr, h_start;
    logic [B_LEN-1:0]      h_len;
    logic                  acc, early;

    feed_hdr_decode #(.B_LEN(B_LEN)) u_dec (
        .word_ctl    (s_tdata[START_BIT:0]),
        .word_len    (s_tdata[LEN_LSB +: B_LEN]),
        .typ         (h_typ),
        .clr         (h_clr),
        .start_after (h_start),
        .len         (h_len)
    );

    assign s_tready = rstn && !halt && !(state_q == S_WEI && wb_full) && !(state_q == S_FTM && fb_full);
    assign acc      = s_tvalid && s_tready;
    assign early    = s_tlast && cnt_q > B_LEN'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        di_d         = di_q;
        para_d       = para_q;
        err_d        = err_q;
        fb_we_d      = 1'b0;
        wb_we_d      = 1'b0;
        fb_clr_d     = 1'b0;
        wb_clr_d     = 1'b0;
        para_we_d    = 1'b0;
        start_pend_d = start_pend_q;
        start_d      = para_we_q && start_pend_q;
        if (acc && state_q == S_HDR) begin
            // a PARA packet always carries exactly one payload word
            cnt_d        = (h_typ == T_PARA) ? B_LEN'(1) : h_len;
            start_pend_d = (h_typ == T_PARA) ? h_start : start_pend_q;
            wb_clr_d     = h_clr && h_typ == T_WEI;
            fb_clr_d     = h_clr && h_typ == T_FTM;
            err_d[0]     = err_q[0] || h_typ == T_RSVD;
            state_d      = (h_typ == T_PARA) ? S_PARA :
                           (h_len == '0)     ? S_HDR  :
                           (h_typ == T_WEI)  ? S_WEI  :
                           (h_typ == T_FTM)  ? S_FTM  : S_DROP;
        end else if (acc) begin
            cnt_d     = early ? '0 : cnt_q - B_LEN'(1);
            state_d   = (early || cnt_q == B_LEN'(1)) ? S_HDR : state_q;
            err_d[1]  = err_q[1] || early;
            wb_we_d   = state_q == S_WEI;
            fb_we_d   = state_q == S_FTM;
            para_we_d = state_q == S_PARA;
            di_d      = (state_q == S_WEI || state_q == S_FTM) ? s_tdata : di_q;
            para_d    = (state_q == S_PARA) ? s_tdata[B_PARA-1:0] : para_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_HDR;
            cnt_q        <= '0;
            di_q         <= '0;
            para_q       <= '0;
            err_q        <= '0;
            fb_we_q      <= 1'b0;
            wb_we_q      <= 1'b0;
            fb_clr_q     <= 1'b0;
            wb_clr_q     <= 1'b0;
            para_we_q    <= 1'b0;
            start_q      <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            di_q         <= di_d;
            para_q       <= para_d;
            err_q        <= err_d;
            fb_we_q      <= fb_we_d;
            wb_we_q      <= wb_we_d;
            fb_clr_q     <= fb_clr_d;
            wb_clr_q     <= wb_clr_d;
            para_we_q    <= para_we_d;
            start_q      <= start_d;
            start_pend_q <= start_pend_d;
        end
    end

    assign di      = di_q;
    assign para    = para_q;
    assign err     = err_q;
    assign fb_we   = fb_we_q;
    assign wb_we   = wb_we_q;
    assign fb_clr  = fb_clr_q;
    assign wb_clr  = wb_clr_q;
    assign para_we = para_we_q;
    assign start   = start_q;
endmodule

// File: tb/tb_conv_feed_ctrl.sv
// tb_conv_feed_ctrl: packet-level reference model and event scoreboard for conv_feed_ctrl
module tb_conv_feed_ctrl;
    localparam int R_HDR = 0, R_PARA = 1, R_WEI = 2, R_FTM = 3, R_DROP = 4;
    localparam int E_START = 0, E_WBCLR = 1, E_FBCLR = 2, E_WBWE = 3, E_FBWE = 4, E_PARA = 5;

    typedef struct {logic [63:0] data; logic last; int role;} word_t;
    typedef struct {int kind; logic [63:0] data;} ev_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, halt = 1'b0, fb_full = 1'b0, wb_full = 1'b0;
    logic        s_tready, fb_we, wb_we, fb_clr, wb_clr, para_we, start;
    logic [63:0] di, para;
    logic [1:0]  err;

    int          checks = 0, fails = 0;
    word_t       q[$];
    ev_t         exp_q[$], act_q[$];
    int          tail_role = R_HDR;
    logic [1:0]  exp_err = 2'b00;
    logic        acc_prev = 1'b0, para_we_prev = 1'b0;
    logic [63:0] acc_data = '0;
    int          fb_hold = 0, hold_at = -1, n_acc = 0, stall_cnt = 0;

    conv_feed_ctrl dut (
        .clk(clk), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .halt(halt), .fb_full(fb_full), .wb_full(wb_full), .di(di),
        .fb_we(fb_we), .wb_we(wb_we), .fb_clr(fb_clr), .wb_clr(wb_clr), .para(para),
        .para_we(para_we), .start(start), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(int typ, bit clr, bit st, int len);
        logic [63:0] h = {$urandom, $urandom};
        h[1:0]   = 2'(typ);
        h[2]     = clr;
        h[3]     = st;
        h[31:16] = 16'(len);
        return h;
    endfunction

    // one packet: header plus 'sent' payload words; short packets end in tlast unless 'cut'
    function automatic void add_pkt(int typ, bit clr, bit st, int len, int sent, bit cut, bit fix, logic [63:0] d0);
        int          n = (typ == 0) ? 1 : len;
        int          role = (typ == 0) ? R_PARA : (typ == 1) ? R_WEI : (typ == 2) ? R_FTM : R_DROP;
        logic [63:0] d;
        logic        l;
        q.push_back('{hdr(typ, clr, st, len), 1'($urandom_range(1)), R_HDR});
        if (typ == 3) exp_err[0] = 1'b1;
        if (clr && typ == 1) exp_q.push_back('{E_WBCLR, 64'd0});
        if (clr && typ == 2) exp_q.push_back('{E_FBCLR, 64'd0});
        for (int i = 0; i < sent; i++) begin
            d = (fix && i == 0) ? d0 : {$urandom, $urandom};
            l = (i == sent - 1) && ((sent < n && !cut) || (sent == n && $urandom_range(1) == 1));
            q.push_back('{d, l, role});
            if (typ == 0) begin
                exp_q.push_back('{E_PARA, d});
                if (st) exp_q.push_back('{E_START, 64'd0});
            end else if (typ == 1) exp_q.push_back('{E_WBWE, d});
            else if (typ == 2) exp_q.push_back('{E_FBWE, d});
        end
        if (sent < n && !cut) exp_err[1] = 1'b1;
        tail_role = (sent < n && cut) ? role : R_HDR;
    endfunction

    task automatic run_stream(int pv, int ph, int pf);
        int   idle = 0, cyc = 0, role;
        logic a, forced, exp_rdy;
        while ((q.size() != 0 || idle < 3) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            s_tvalid = q.size() != 0 && $urandom_range(99) < pv;
            s_tdata  = q.size() != 0 ? q[0].data : {$urandom, $urandom};
            s_tlast  = q.size() != 0 ? q[0].last : 1'($urandom_range(1));
            halt     = $urandom_range(99) < ph;
            wb_full  = $urandom_range(99) < pf;
            forced   = fb_hold > 0;
            fb_full  = forced || $urandom_range(99) < pf;
            if (forced) fb_hold--;
            role = q.size() != 0 ? q[0].role : tail_role;
            #1;
            exp_rdy = !halt && !(role == R_WEI && wb_full) && !(role == R_FTM && fb_full);
            chk("tready", s_tready, exp_rdy);
            if (forced && !s_tready) stall_cnt++;
            a = s_tvalid && s_tready;
            @(posedge clk);
            acc_prev = a;
            acc_data = s_tdata;
            if (a) begin
                void'(q.pop_front());
                n_acc++;
                if (n_acc == hold_at) fb_hold = 5;
            end
            idle = q.size() == 0 ? idle + 1 : 0;
        end
        if (q.size() != 0) chk("stream_timeout", 64'(q.size()), 0);
        s_tvalid = 1'b0;
        halt     = 1'b0;
        fb_full  = 1'b0;
        wb_full  = 1'b0;
    endtask

    task automatic cmp_events(string tag);
        chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk({tag, "_kind"}, 64'(act_q[i].kind), 64'(exp_q[i].kind));
            chk({tag, "_data"}, act_q[i].data, exp_q[i].data);
        end
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        halt     = 1'b0;
        fb_full  = 1'b0;
        wb_full  = 1'b0;
        q.delete();
        tail_role = R_HDR;
        exp_err   = 2'b00;
        acc_prev  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_tready, 0);
        chk("rst_di", di, 0);
        chk("rst_para", para, 0);
        chk("rst_ctl", {fb_we, wb_we, fb_clr, wb_clr, para_we, start, err}, 0);
        rstn = 1'b1;
    endtask

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (start) begin
                act_q.push_back('{E_START, 64'd0});
                chk("start_after_para_we", para_we_prev, 1);
            end
            if (wb_clr) begin
                act_q.push_back('{E_WBCLR, 64'd0});
                chk("wb_clr_latency", acc_prev, 1);
                chk("wb_clr_we_overlap", wb_we, 0);
            end
            if (fb_clr) begin
                act_q.push_back('{E_FBCLR, 64'd0});
                chk("fb_clr_latency", acc_prev, 1);
                chk("fb_clr_we_overlap", fb_we, 0);
            end
            if (wb_we) begin
                act_q.push_back('{E_WBWE, di});
                chk("wb_we_latency", acc_prev, 1);
                chk("wb_we_di", di, acc_data);
            end
            if (fb_we) begin
                act_q.push_back('{E_FBWE, di});
                chk("fb_we_latency", acc_prev, 1);
                chk("fb_we_di", di, acc_data);
            end
            if (para_we) begin
                act_q.push_back('{E_PARA, para});
                chk("para_we_latency", acc_prev, 1);
                chk("para_we_data", para, acc_data);
            end
        end
        para_we_prev = para_we;
    end

    initial begin
        do_reset();

        add_pkt(1, 1, 0, 3, 3, 0, 0, 0);
        add_pkt(2, 0, 0, 1, 1, 0, 0, 0);
        run_stream(100, 0, 0);
        cmp_events("wei_clr");

        add_pkt(0, 0, 1, 0, 1, 0, 1, 64'h0000_0123_4567_89AB);
        run_stream(100, 0, 0);
        cmp_events("para_start");
        chk("para_value", para, 64'h0000_0123_4567_89AB);

        n_acc     = 0;
        hold_at   = 3;
        stall_cnt = 0;
        add_pkt(2, 0, 0, 4, 4, 0, 0, 0);
        run_stream(100, 0, 0);
        hold_at = -1;
        chk("ftm_full_stall_cycles", 64'(stall_cnt), 5);
        cmp_events("ftm_full");

        add_pkt(3, 0, 0, 2, 2, 0, 0, 0);
        add_pkt(2, 1, 0, 1, 1, 0, 0, 0);
        run_stream(100, 0, 0);
        cmp_events("drop");

        add_pkt(2, 0, 0, 5, 2, 0, 0, 0);
        add_pkt(1, 0, 0, 2, 2, 0, 0, 0);
        run_stream(100, 0, 0);
        cmp_events("early_tlast");

        add_pkt(1, 0, 0, 3, 1, 1, 0, 0);
        run_stream(100, 0, 0);
        cmp_events("wei_partial");
        do_reset();
        add_pkt(2, 0, 0, 1, 1, 0, 0, 0);
        run_stream(100, 0, 0);
        cmp_events("after_reset");

        for (int p = 0; p < 80; p++) begin
            int typ = $urandom_range(3);
            int len = $urandom_range(4);
            int n   = (typ == 0) ? 1 : len;
            int sent = (typ != 0 && len >= 2 && $urandom_range(4) == 0) ? $urandom_range(len - 1, 1) : n;
            add_pkt(typ, 1'($urandom_range(1)), 1'($urandom_range(1)), len, sent, 0, 0, 0);
        end
        run_stream(70, 15, 20);
        cmp_events("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/conv_feed_ctrl.md
CONV_FEED_CTRL -- requirements
Module: conv_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream and buffer word width.
REQ-002 SHALL have parameter B_PARA, default 64, layer parameter word width; B_PARA SHALL be no greater than DATA_WIDTH.
REQ-003 SHALL have parameter B_LEN, default 16, payload length counter width.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rstn, input, 1 bit, reset: synchronous, active-low.
REQ-006 SHALL have port s_tdata, input, DATA_WIDTH bits, inbound stream data.
REQ-007 SHALL have ports s_tvalid (input, 1 bit), s_tlast (input, 1 bit) and s_tready (output, 1 bit), the stream handshake.
REQ-008 SHALL have port halt, input, 1 bit, freezes stream acceptance.
REQ-009 SHALL have ports fb_full and wb_full, input, 1 bit each, conv-unit buffer full flags.
REQ-010 SHALL have port di, output, DATA_WIDTH bits, registered write data shared by both buffers.
REQ-011 SHALL have ports fb_we, wb_we, fb_clr and wb_clr, output, 1 bit each, buffer write and clear strobes.
REQ-012 SHALL have ports para (output, B_PARA bits) and para_we (output, 1 bit), the layer parameter word and its write strobe.
REQ-013 SHALL have port start, output, 1 bit, one-cycle compute start pulse.
REQ-014 SHALL have port err, output, 2 bits: bit0 = reserved type seen, bit1 = early tlast; both sticky.

Function
REQ-015 Header word fields SHALL be: [1:0] type (0 = PARA, 1 = WEI, 2 = FTM, 3 = reserved), [2] clr, [3] start_after, [B_LEN+15:16] len, counted in payload words.
REQ-016 States SHALL be HDR, PARA, WEI, FTM and DROP; HDR is the reset state.
REQ-017 In HDR, an accepted word SHALL be decoded as a header; type 0/1/2/3 SHALL go to PARA/WEI/FTM/DROP respectively, and len is latched.
REQ-018 If len is 0, the block SHALL stay in HDR; for a PARA header, len SHALL be treated as 1 regardless of the field.
REQ-019 s_tready SHALL equal !halt && (state is HDR, PARA or DROP, or (state is WEI and !wb_full), or (state is FTM and !fb_full)); it is combinational.
REQ-020 An accepted payload word SHALL appear on di with fb_we or wb_we high for exactly one cycle, on the cycle after acceptance (latency 1).
REQ-021 When a full flag rises in the same cycle as an acceptance, that one write SHALL still issue; the buffers reserve one slot of margin for it.
REQ-022 PARA payload SHALL load para <= s_tdata[B_PARA-1:0] with para_we pulsed at latency 1.
REQ-023 If start_after is set in the PARA header, start SHALL pulse in the cycle after para_we.
REQ-024 A header with clr=1 and type WEI or FTM SHALL pulse wb_clr or fb_clr one cycle after header acceptance, at least one cycle before the first matching we.
REQ-025 DROP SHALL consume len words with no strobes and SHALL set err[0] at header acceptance.
REQ-026 The remaining-word counter SHALL decrement per accepted payload word; the state SHALL return to HDR after the word that brings it to 0.
REQ-027 tlast on a payload word with count > 1 SHALL set err[1] and return the state to HDR; the word itself SHALL still be written.
REQ-028 tlast on a header SHALL be ignored; tlast absent on the final payload word SHALL NOT be an error.
REQ-029 halt SHALL stall acceptance only; in-flight strobes SHALL complete, and the state and counter SHALL hold.
REQ-030 Counter arithmetic SHALL be unsigned B_LEN bits with no wrap, since the counter never decrements past 0.

Reset
REQ-031 On rstn low at a clock edge: state = HDR; counter = 0; di = 0; para = 0; err = 0; all strobes and start = 0; s_tready = 0 while rstn is low.
REQ-032 Reset mid-payload SHALL discard the transfer; the next accepted word after reset is a header.

Structure
REQ-033 Type codes, header field offsets and state encodings SHALL live in the shared package conv_pkg.
REQ-034 Header decode SHALL be a sub-module, feed_hdr_decode, combinational, taking the word and producing type, clr, start_after and len.
REQ-035 All outputs SHALL be registered except s_tready.

Verification
REQ-036 Header {type=1, clr=1, len=3} then words A, B, C -> wb_clr pulses once, then wb_we is high 3 times with di = A, B, C at latency 1, and the state returns to HDR.
REQ-037 Header {type=2, len=4} with fb_full asserted after word 2 for 5 cycles -> s_tready low for those 5 cycles, exactly 4 fb_we pulses total, no data lost.
REQ-038 Header {type=0, start_after=1} then word 0x0000_0123_4567_89AB -> para = that word, para_we pulses, then start pulses the following cycle.
REQ-039 Header {type=3, len=2} then 2 words -> no strobes, err = 2'b01, the next header is decoded correctly.
REQ-040 Header {type=2, len=5}, tlast on word 2 -> 2 fb_we pulses, err[1] = 1, the third word is decoded as a header.
REQ-041 rstn low after 1 of 3 WEI words, then FTM header len=1 -> a single fb_we, no further wb_we, err = 0.
